// File: rtl/div_pkg.sv
// Shared constants for the sequential DKG divider.
package div_pkg;

    // Default operand width for dividend, divisor, quotient and remainder.
    localparam int unsigned DEFAULT_WIDTH = 64;

    // Quotient reported when the divisor is zero.
    localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = {DEFAULT_WIDTH{1'b1}};

    // FSM state encodings.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/dkg_subtractor.sv
// Ripple subtractor built from DKG reversible-gate cells: a - b as a + ~b + 1.
module dkg_subtractor #(
    parameter int unsigned N = 65
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_n_o
);

    logic [N:0] carry;

    // Carry-in of one completes the two's-complement negation of b.
    assign carry[0] = 1'b1;

    // With A tied low a DKG cell is a full adder: R = carry out, S = sum.
    for (genvar i = 0; i < N; i++) begin : g_cell
        logic gate_a;
        logic gate_b;
        logic gate_c;
        logic gate_d;

        assign gate_a = 1'b0;
        assign gate_b = a_i[i];
        assign gate_c = ~b_i[i];
        assign gate_d = carry[i];

        assign carry[i+1] = ((gate_a ^ gate_b) & (gate_c ^ gate_d)) ^ (gate_c & gate_d);
        assign diff_o[i]  = gate_b ^ gate_c ^ gate_d;
    end

    // Final carry high means no borrow occurred.
    assign borrow_n_o = carry[N];

endmodule

// File: rtl/seq_divider_dkg.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider_dkg
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_diff;
    logic             trial_ok;
    logic             unused_rem_msb;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign trial_a = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

    dkg_subtractor #(
        .N(WIDTH + 1)
    ) u_sub (
        .a_i       (trial_a),
        .b_i       ({1'b0, div_q}),
        .diff_o    (trial_diff),
        .borrow_n_o(trial_ok)
    );

    // Remainder never exceeds the divisor, so its top bit is always zero once stored.
    assign unused_rem_msb = rem_q[WIDTH];

    // Next-state logic: operand load, one restoring step per RUN cycle, result handoff.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_d = divisor;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                        rem_d   = '0;
                        quo_d   = dividend;
                        cnt_d   = CNT_W'(WIDTH);
                    end
                end
            end
            RUN: begin
                rem_d = trial_ok ? trial_diff : trial_a;
                quo_d = {quo_q[WIDTH-2:0], trial_ok};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    quotient_d  = quo_d;
                    remainder_d = rem_d[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset has priority over any in-flight division.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider_dkg.md
Name: seq_divider_dkg

Overview:
- Iterative unsigned radix-2 restoring divider, one quotient bit per clock.
- Inverse-operation companion to the Vedic MAC: consumes wide operands, e.g. accumulator value / sample count for averaging or normalisation.
- Trial subtraction is built from DKG reversible-gate cells, used as subtractors via inverted divisor and carry-in = 1.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 64, operand width for dividend, divisor, quotient and remainder.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  set with result when divisor was 0
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset is decided: reset reset, synchronous, active-high; clock clk.
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; quotient, remainder, div_by_zero = 0; internal rem/quo/div/cnt = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, register operands and go to RUN.
  - If divisor==0, skip RUN and go to DONE next cycle with quotient = all-ones, remainder = dividend, div_by_zero=1.
- Load, divisor nonzero: rem(WIDTH+1 bits)=0, quo=dividend, div=divisor, cnt=WIDTH.
- RUN, every cycle:
  - trial = {rem[WIDTH-1:0], quo[WIDTH-1]} - {1'b0, div}, computed by the sub-module over WIDTH+1 bits.
  - No borrow: rem=trial, quo={quo[WIDTH-2:0],1}.
  - Borrow: rem={rem[WIDTH-1:0], quo[WIDTH-1]}, quo={quo[WIDTH-2:0],0}.
  - cnt decrements. When cnt reaches 1 and is processed, go to DONE.
- Latency: handshake cycle T; WIDTH iterations in cycles T+1..T+WIDTH; out_valid=1 from cycle T+WIDTH+1.
  - Divide-by-zero latency: out_valid at T+1.
- DONE:
  - out_valid=1; quotient/remainder/div_by_zero are stable and hold while out_ready=0.
  - On out_valid && out_ready, go to IDLE; out_valid drops next cycle.
- No input pipelining: in_ready=0 in RUN and DONE. in_valid in those states is ignored, not queued.
- Same-cycle accept after result handoff is not supported: in_ready rises the cycle after DONE exits.
- Output registers update only on entry to DONE and keep their last values while in IDLE.
- Reset in any state, including mid-RUN, has priority: IDLE next cycle, all outputs at reset values, partial result discarded.
- Dividend < divisor gives quotient 0, remainder = dividend.
- Invariant: quotient*divisor + remainder == dividend, with remainder < divisor.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Default WIDTH constant.
  - DIV0_QUOTIENT constant (all-ones).
- Sub-module dkg_subtractor (combinational, parameter N = WIDTH+1):
  - Ripple of DKG cells with A=0, C=~b[i], first carry-in = 1.
  - Outputs diff[N-1:0] and borrow_n (final carry; 1 = no borrow).
- Divider top holds the FSM, counter and shift registers only.

Test Plan:
- 100/7, WIDTH=64: in_valid at T -> out_valid at T+65, quotient=14, remainder=2, div_by_zero=0, busy high T+1..T+65.
- 5/9 -> quotient=0, remainder=5. 2^64-1 / 1 -> quotient=2^64-1, remainder=0. 2^64-1 / 2^64-1 -> quotient=1, remainder=0.
- 1234/0 -> out_valid at T+1, quotient=all-ones, remainder=1234, div_by_zero=1.
- Backpressure on 1000/10: out_ready low 10 cycles after out_valid -> quotient=100, remainder=0 held stable, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE next cycle, in_ready=1.
- Reset asserted 20 cycles into RUN -> next cycle state=IDLE, out_valid=0, outputs 0; a following 81/9 returns 9 r 0 with normal latency.
- Random regression of 10k operand pairs including the 0, 1 and all-ones corners -> quotient and remainder match the reference model `/` and `%` every transaction.
